// File: rtl/hdmi_audio_pkg.sv
// -----------------------------------------------------------------------------
// hdmi_audio_pkg
// Shared constants, FSM state type and frame-counter arithmetic for the HDMI
// audio sample path.
// -----------------------------------------------------------------------------
package hdmi_audio_pkg;

  localparam int CHANNEL_STATUS_LENGTH = 192;
  localparam int SAMPLES_PER_PACKET    = 4;
  localparam int AUDIO_WORD_WIDTH      = 24;

  // Slot index width and "number of samples in a packet" width (0..4).
  localparam int SLOT_W = $clog2(SAMPLES_PER_PACKET);
  localparam int NUM_W  = SLOT_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_EMIT  = 2'd2
  } buf_state_t;

  // Advance the channel-status frame index by n samples, wrapping at 192.
  // The sum is formed at 9 bits so 191 + 4 cannot overflow before the wrap.
  function automatic logic [7:0] advance_frame(input logic [7:0]       fc,
                                               input logic [NUM_W-1:0] n);
    logic [8:0] sum;
    sum = {1'b0, fc} + 9'(n);
    if (sum >= 9'(CHANNEL_STATUS_LENGTH)) begin
      sum = sum - 9'(CHANNEL_STATUS_LENGTH);
    end
    return sum[7:0];
  endfunction

endpackage

// File: rtl/audio_sample_buffer_if.sv
// -----------------------------------------------------------------------------
// audio_sample_buffer_if
// Stereo L-PCM sample stream with valid/ready handshake.
//   sample_valid  source -> sink  sample available
//   sample_ready  sink -> source  sink can accept a sample
//   sample_left   source -> sink  24-bit left-channel word
//   sample_right  source -> sink  24-bit right-channel word
// A sample transfers on any clock edge where valid and ready are both high.
// -----------------------------------------------------------------------------
interface audio_sample_buffer_if;
  import hdmi_audio_pkg::*;

  logic                        sample_valid;
  logic                        sample_ready;
  logic [AUDIO_WORD_WIDTH-1:0] sample_left;
  logic [AUDIO_WORD_WIDTH-1:0] sample_right;

  modport master (
    output sample_valid,
    output sample_left,
    output sample_right,
    input  sample_ready
  );

  modport slave (
    input  sample_valid,
    input  sample_left,
    input  sample_right,
    output sample_ready
  );

endinterface

// File: rtl/audio_sample_fifo.sv
// -----------------------------------------------------------------------------
// audio_sample_fifo
// Synchronous single-clock FIFO with show-ahead read data and occupancy count.
//   clk      clock
//   reset    synchronous active-high reset (empties the FIFO)
//   push     write wr_data (ignored when full)
//   wr_data  write data
//   pop      advance read pointer (ignored when empty)
//   rd_data  word at the head of the FIFO (valid when !empty)
//   count    occupancy, 0..FIFO_DEPTH
//   full     count == FIFO_DEPTH
//   empty    count == 0
// FIFO_DEPTH must be a power of two so pointers wrap naturally at AW bits.
// -----------------------------------------------------------------------------
module audio_sample_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int AW         = 3,
  parameter int WIDTH      = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] DEPTH_COUNT = (AW + 1)'(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: storage array has no reset; contents are only observable once
  // count says they were written, and resetting it would turn the RAM into flops.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop) begin
        count <= count + (AW + 1)'(1);
      end else if (do_pop && !do_push) begin
        count <= count - (AW + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/audio_sample_buffer.sv
// -----------------------------------------------------------------------------
// audio_sample_buffer
// Buffers stereo L-PCM samples and, on each packet_req, drains up to four of
// them into the slot set consumed by the HDMI audio sample packet generator.
//   clk_pixel                  pixel clock
//   reset                      synchronous active-high reset
//   sample_if (slave)          sample stream: valid/ready/left/right
//   packet_req                 one-cycle pulse, a packet slot is available
//   packet_valid               one-cycle pulse, packet outputs updated
//   frame_counter              channel-status frame index of slot 0 (0..191)
//   audio_sample_word[8]       word 2k = left of slot k, 2k+1 = right of slot k
//   audio_sample_word_present  bit k set = slot k carries a sample
//   valid_bit[4]               per slot, [0] = left, [1] = right
//   user_data_bit[4]           per slot, [0] = left, [1] = right
//   busy                       drain/emit in progress
//   overflow                   sticky, sample offered while FIFO full
// Latency: req sampled at cycle t, pops t+1..t+n, packet_valid at t+n+2.
// -----------------------------------------------------------------------------
module audio_sample_buffer
  import hdmi_audio_pkg::*;
#(
  parameter int   FIFO_DEPTH      = 8,
  parameter int   AW              = 3,
  parameter logic VALID_BIT_VALUE = 1'b0,
  parameter logic USER_BIT_VALUE  = 1'b0
) (
  input  logic                          clk_pixel,
  input  logic                          reset,
  audio_sample_buffer_if.slave          sample_if,
  input  logic                          packet_req,
  output logic                          packet_valid,
  output logic [7:0]                    frame_counter,
  output logic [AUDIO_WORD_WIDTH-1:0]   audio_sample_word [2*SAMPLES_PER_PACKET],
  output logic [SAMPLES_PER_PACKET-1:0] audio_sample_word_present,
  output logic [1:0]                    valid_bit [SAMPLES_PER_PACKET],
  output logic [1:0]                    user_data_bit [SAMPLES_PER_PACKET],
  output logic                          busy,
  output logic                          overflow
);

  localparam int FIFO_W = 2 * AUDIO_WORD_WIDTH;

  buf_state_t state;
  buf_state_t next_state;

  logic [FIFO_W-1:0] fifo_rd_data;
  logic [AW:0]       fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;

  logic              load;
  logic              pop;
  logic              emit;
  logic [NUM_W-1:0]  avail_n;
  logic [NUM_W-1:0]  drain_n;
  logic [SLOT_W-1:0] slot;
  logic [7:0]        fc;

  logic [AUDIO_WORD_WIDTH-1:0]   stage_word [2*SAMPLES_PER_PACKET];
  logic [SAMPLES_PER_PACKET-1:0] stage_present;
  logic [1:0]                    stage_valid [SAMPLES_PER_PACKET];
  logic [1:0]                    stage_user [SAMPLES_PER_PACKET];

  // ---------------------------------------------------------------------------
  // Sample FIFO; each entry is {left, right}.
  // ---------------------------------------------------------------------------
  assign sample_if.sample_ready = !fifo_full;
  assign fifo_push = sample_if.sample_valid && !fifo_full;

  audio_sample_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .AW         (AW),
    .WIDTH      (FIFO_W)
  ) u_fifo (
    .clk     (clk_pixel),
    .reset   (reset),
    .push    (fifo_push),
    .wr_data ({sample_if.sample_left, sample_if.sample_right}),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Samples taken by the next packet: min(count, 4).
  assign avail_n = (fifo_count >= (AW + 1)'(SAMPLES_PER_PACKET))
                 ? NUM_W'(SAMPLES_PER_PACKET)
                 : NUM_W'(fifo_count);

  assign busy = (state != ST_IDLE);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_pixel) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and infers a latch.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    pop        = 1'b0;
    emit       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (packet_req) begin
          load = 1'b1;
          if (avail_n != '0) next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The snapshot guarantees enough entries; the empty guard only keeps
        // a corrupted drain_n from popping an empty FIFO.
        pop = !fifo_empty;
        if ({1'b0, slot} == drain_n - NUM_W'(1)) next_state = ST_EMIT;
      end
      ST_EMIT: begin
        emit       = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Staging, output registers, frame counter, overflow flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      drain_n                   <= '0;
      slot                      <= '0;
      fc                        <= '0;
      packet_valid              <= 1'b0;
      frame_counter             <= '0;
      audio_sample_word_present <= '0;
      stage_present             <= '0;
      overflow                  <= 1'b0;
      for (int i = 0; i < 2*SAMPLES_PER_PACKET; i++) begin
        stage_word[i]        <= '0;
        audio_sample_word[i] <= '0;
      end
      for (int i = 0; i < SAMPLES_PER_PACKET; i++) begin
        stage_valid[i]   <= '0;
        stage_user[i]    <= '0;
        valid_bit[i]     <= '0;
        user_data_bit[i] <= '0;
      end
    end else begin
      packet_valid <= 1'b0;

      if (load) begin
        drain_n       <= avail_n;
        slot          <= '0;
        stage_present <= '0;
        for (int i = 0; i < 2*SAMPLES_PER_PACKET; i++) stage_word[i] <= '0;
        for (int i = 0; i < SAMPLES_PER_PACKET; i++) begin
          stage_valid[i] <= '0;
          stage_user[i]  <= '0;
        end
      end

      if (pop) begin
        stage_word[{slot, 1'b0}] <= fifo_rd_data[FIFO_W-1:AUDIO_WORD_WIDTH];
        stage_word[{slot, 1'b1}] <= fifo_rd_data[AUDIO_WORD_WIDTH-1:0];
        stage_present[slot]      <= 1'b1;
        stage_valid[slot]        <= {2{VALID_BIT_VALUE}};
        stage_user[slot]         <= {2{USER_BIT_VALUE}};
        slot                     <= slot + SLOT_W'(1);
      end

      if (emit) begin
        audio_sample_word         <= stage_word;
        audio_sample_word_present <= stage_present;
        valid_bit                 <= stage_valid;
        user_data_bit             <= stage_user;
        frame_counter             <= fc;
        fc                        <= advance_frame(fc, drain_n);
        packet_valid              <= 1'b1;
      end

      if (sample_if.sample_valid && fifo_full) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_audio_sample_buffer.sv
// -----------------------------------------------------------------------------
// tb_audio_sample_buffer
// Directed self-checking bench for audio_sample_buffer. The DUT is built with
// VALID_BIT_VALUE = 1 so occupied slots (11) are distinguishable from empty
// ones (00); USER_BIT_VALUE stays 0.
// -----------------------------------------------------------------------------
module tb_audio_sample_buffer;
  import hdmi_audio_pkg::*;

  logic        clk_pixel;
  logic        reset;
  logic        packet_req;
  logic        packet_valid;
  logic [7:0]  frame_counter;
  logic [23:0] audio_sample_word [8];
  logic [3:0]  audio_sample_word_present;
  logic [1:0]  valid_bit [4];
  logic [1:0]  user_data_bit [4];
  logic        busy;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  audio_sample_buffer_if sif ();

  audio_sample_buffer #(
    .FIFO_DEPTH      (8),
    .AW              (3),
    .VALID_BIT_VALUE (1'b1),
    .USER_BIT_VALUE  (1'b0)
  ) dut (
    .clk_pixel                 (clk_pixel),
    .reset                     (reset),
    .sample_if                 (sif),
    .packet_req                (packet_req),
    .packet_valid              (packet_valid),
    .frame_counter             (frame_counter),
    .audio_sample_word         (audio_sample_word),
    .audio_sample_word_present (audio_sample_word_present),
    .valid_bit                 (valid_bit),
    .user_data_bit             (user_data_bit),
    .busy                      (busy),
    .overflow                  (overflow)
  );

  initial clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no comparisons inside)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic apply_reset();
    reset            = 1'b1;
    packet_req       = 1'b0;
    sif.sample_valid = 1'b0;
    sif.sample_left  = '0;
    sif.sample_right = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push_sample(input logic [23:0] l, input logic [23:0] r);
    sif.sample_valid = 1'b1;
    sif.sample_left  = l;
    sif.sample_right = r;
    tick();
    sif.sample_valid = 1'b0;
  endtask

  // Pulse packet_req for one cycle (cycle t) and wait for packet_valid.
  // lat is the cycle offset t+lat at which packet_valid is seen, -1 if never.
  task automatic do_packet(output int lat, output logic busy_seen);
    int k;
    packet_req = 1'b1;
    tick();
    packet_req = 1'b0;
    busy_seen  = busy;
    k = 0;
    while (packet_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    lat = (packet_valid === 1'b1) ? k + 1 : -1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    apply_reset();
    total++; if (sif.sample_ready !== 1'b1) begin $display("FAIL rst_ready got=%b want=1", sif.sample_ready); bad++; end
    total++; if (packet_valid !== 1'b0) begin $display("FAIL rst_pvalid got=%b want=0", packet_valid); bad++; end
    total++; if (frame_counter !== 8'd0) begin $display("FAIL rst_fc got=%0d want=0", frame_counter); bad++; end
    total++; if (audio_sample_word_present !== 4'b0000) begin $display("FAIL rst_present got=%b want=0000", audio_sample_word_present); bad++; end
    total++; if (busy !== 1'b0) begin $display("FAIL rst_busy got=%b want=0", busy); bad++; end
    total++; if (overflow !== 1'b0) begin $display("FAIL rst_overflow got=%b want=0", overflow); bad++; end
    for (int i = 0; i < 8; i++) begin
      total++; if (audio_sample_word[i] !== 24'h0) begin $display("FAIL rst_word%0d got=%h want=000000", i, audio_sample_word[i]); bad++; end
    end
    for (int i = 0; i < 4; i++) begin
      total++; if (valid_bit[i] !== 2'b00 || user_data_bit[i] !== 2'b00) begin
        $display("FAIL rst_bits%0d got=v%b/u%b want=v00/u00", i, valid_bit[i], user_data_bit[i]); bad++;
      end
    end
  endtask

  task automatic test_full_packet();
    int   lat;
    logic bs;
    apply_reset();
    for (int i = 1; i <= 4; i++) push_sample(24'(i), 24'h100000 + 24'(i));
    do_packet(lat, bs);
    total++; if (lat !== 6) begin $display("FAIL full_latency got=%0d want=6", lat); bad++; end
    total++; if (bs !== 1'b1) begin $display("FAIL full_busy_drain got=%b want=1", bs); bad++; end
    total++; if (audio_sample_word_present !== 4'b1111) begin $display("FAIL full_present got=%b want=1111", audio_sample_word_present); bad++; end
    total++; if (audio_sample_word[0] !== 24'h000001) begin $display("FAIL full_word0 got=%h want=000001", audio_sample_word[0]); bad++; end
    total++; if (audio_sample_word[1] !== 24'h100001) begin $display("FAIL full_word1 got=%h want=100001", audio_sample_word[1]); bad++; end
    total++; if (audio_sample_word[6] !== 24'h000004) begin $display("FAIL full_word6 got=%h want=000004", audio_sample_word[6]); bad++; end
    total++; if (audio_sample_word[7] !== 24'h100004) begin $display("FAIL full_word7 got=%h want=100004", audio_sample_word[7]); bad++; end
    total++; if (frame_counter !== 8'd0) begin $display("FAIL full_fc got=%0d want=0", frame_counter); bad++; end
    total++; if (valid_bit[3] !== 2'b11 || user_data_bit[3] !== 2'b00) begin
      $display("FAIL full_bits3 got=v%b/u%b want=v11/u00", valid_bit[3], user_data_bit[3]); bad++;
    end
    total++; if (busy !== 1'b0) begin $display("FAIL full_busy_end got=%b want=0", busy); bad++; end
    tick();
    total++; if (packet_valid !== 1'b0) begin $display("FAIL full_pulse_width got=%b want=0", packet_valid); bad++; end
    total++; if (audio_sample_word_present !== 4'b1111) begin $display("FAIL full_hold got=%b want=1111", audio_sample_word_present); bad++; end
    // Next packet carries one sample and reports the advanced frame index.
    push_sample(24'h000055, 24'h000066);
    do_packet(lat, bs);
    total++; if (lat !== 3) begin $display("FAIL next_latency got=%0d want=3", lat); bad++; end
    total++; if (frame_counter !== 8'd4) begin $display("FAIL next_fc got=%0d want=4", frame_counter); bad++; end
    total++; if (audio_sample_word_present !== 4'b0001) begin $display("FAIL next_present got=%b want=0001", audio_sample_word_present); bad++; end
    total++; if (audio_sample_word[2] !== 24'h0 || valid_bit[1] !== 2'b00) begin
      $display("FAIL next_cleared got=w%h/v%b want=w000000/v00", audio_sample_word[2], valid_bit[1]); bad++;
    end
  endtask

  task automatic test_partial();
    int   lat;
    logic bs;
    apply_reset();
    push_sample(24'h111111, 24'h333333);
    push_sample(24'h222222, 24'h444444);
    do_packet(lat, bs);
    total++; if (lat !== 4) begin $display("FAIL part2_latency got=%0d want=4", lat); bad++; end
    total++; if (audio_sample_word_present !== 4'b0011) begin $display("FAIL part2_present got=%b want=0011", audio_sample_word_present); bad++; end
    total++; if (audio_sample_word[2] !== 24'h222222 || audio_sample_word[3] !== 24'h444444) begin
      $display("FAIL part2_slot1 got=%h/%h want=222222/444444", audio_sample_word[2], audio_sample_word[3]); bad++;
    end
    for (int i = 4; i < 8; i++) begin
      total++; if (audio_sample_word[i] !== 24'h0) begin $display("FAIL part2_word%0d got=%h want=000000", i, audio_sample_word[i]); bad++; end
    end
    total++; if (valid_bit[0] !== 2'b11 || valid_bit[2] !== 2'b00 || valid_bit[3] !== 2'b00) begin
      $display("FAIL part2_valid got=%b/%b/%b want=11/00/00", valid_bit[0], valid_bit[2], valid_bit[3]); bad++;
    end
    total++; if (frame_counter !== 8'd0) begin $display("FAIL part2_fc got=%0d want=0", frame_counter); bad++; end
    push_sample(24'h000a01, 24'h000b01);
    push_sample(24'h000a02, 24'h000b02);
    push_sample(24'h000a03, 24'h000b03);
    do_packet(lat, bs);
    total++; if (lat !== 5) begin $display("FAIL part3_latency got=%0d want=5", lat); bad++; end
    total++; if (audio_sample_word_present !== 4'b0111) begin $display("FAIL part3_present got=%b want=0111", audio_sample_word_present); bad++; end
    total++; if (frame_counter !== 8'd2) begin $display("FAIL part3_fc got=%0d want=2", frame_counter); bad++; end
    total++; if (audio_sample_word[4] !== 24'h000a03 || audio_sample_word[7] !== 24'h0) begin
      $display("FAIL part3_words got=%h/%h want=000a03/000000", audio_sample_word[4], audio_sample_word[7]); bad++;
    end
  endtask

  task automatic test_frame_wrap();
    int   lat;
    logic bs;
    apply_reset();
    for (int p = 0; p < 95; p++) begin
      push_sample(24'(2*p), 24'(2*p + 1));
      push_sample(24'(2*p + 2), 24'(2*p + 3));
      do_packet(lat, bs);
      total++; if (lat !== 4) begin $display("FAIL wrap_pkt%0d_latency got=%0d want=4", p, lat); bad++; end
    end
    total++; if (frame_counter !== 8'd188) begin $display("FAIL wrap_fc188 got=%0d want=188", frame_counter); bad++; end
    for (int i = 0; i < 4; i++) push_sample(24'hc00000 + 24'(i), 24'hd00000 + 24'(i));
    do_packet(lat, bs);
    total++; if (frame_counter !== 8'd190) begin $display("FAIL wrap_fc190 got=%0d want=190", frame_counter); bad++; end
    total++; if (audio_sample_word_present !== 4'b1111) begin $display("FAIL wrap_present got=%b want=1111", audio_sample_word_present); bad++; end
    push_sample(24'h0000ee, 24'h0000ff);
    do_packet(lat, bs);
    total++; if (frame_counter !== 8'd2) begin $display("FAIL wrap_fc2 got=%0d want=2", frame_counter); bad++; end
  endtask

  task automatic test_empty_and_ignore();
    int   lat;
    logic bs;
    int   pulses;
    logic busy_any;
    apply_reset();
    push_sample(24'habcdef, 24'h123456);
    do_packet(lat, bs);
    total++; if (audio_sample_word_present !== 4'b0001) begin $display("FAIL ign_first_present got=%b want=0001", audio_sample_word_present); bad++; end
    // Request against an empty FIFO: nothing happens.
    packet_req = 1'b1;
    tick();
    packet_req = 1'b0;
    pulses = 0;
    busy_any = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (packet_valid === 1'b1) pulses++;
      if (busy !== 1'b0) busy_any = 1'b1;
      tick();
    end
    total++; if (pulses !== 0) begin $display("FAIL empty_pulses got=%0d want=0", pulses); bad++; end
    total++; if (busy_any !== 1'b0) begin $display("FAIL empty_busy got=%b want=0", busy_any); bad++; end
    total++; if (audio_sample_word_present !== 4'b0001 || audio_sample_word[0] !== 24'habcdef) begin
      $display("FAIL empty_hold got=%b/%h want=0001/abcdef", audio_sample_word_present, audio_sample_word[0]); bad++;
    end
    total++; if (frame_counter !== 8'd0) begin $display("FAIL empty_fc got=%0d want=0", frame_counter); bad++; end
    // Second request while draining three samples must be dropped.
    for (int i = 0; i < 3; i++) push_sample(24'h700000 + 24'(i), 24'h800000 + 24'(i));
    packet_req = 1'b1;
    tick();
    packet_req = 1'b0;
    tick();
    packet_req = 1'b1;
    tick();
    packet_req = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (packet_valid === 1'b1) pulses++;
      tick();
    end
    total++; if (pulses !== 1) begin $display("FAIL ign_pulses got=%0d want=1", pulses); bad++; end
    total++; if (audio_sample_word_present !== 4'b0111) begin $display("FAIL ign_present got=%b want=0111", audio_sample_word_present); bad++; end
    total++; if (frame_counter !== 8'd1) begin $display("FAIL ign_fc got=%0d want=1", frame_counter); bad++; end
  endtask

  task automatic test_overflow();
    int   lat;
    logic bs;
    apply_reset();
    sif.sample_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sif.sample_left  = 24'ha00000 + 24'(i);
      sif.sample_right = 24'hb00000 + 24'(i);
      total++; if (sif.sample_ready !== 1'b1) begin $display("FAIL ovf_ready_push%0d got=%b want=1", i, sif.sample_ready); bad++; end
      tick();
    end
    total++; if (sif.sample_ready !== 1'b0) begin $display("FAIL ovf_ready_full got=%b want=0", sif.sample_ready); bad++; end
    total++; if (overflow !== 1'b0) begin $display("FAIL ovf_early got=%b want=0", overflow); bad++; end
    sif.sample_left  = 24'ha00008;
    sif.sample_right = 24'hb00008;
    tick();
    sif.sample_valid = 1'b0;
    total++; if (overflow !== 1'b1) begin $display("FAIL ovf_set got=%b want=1", overflow); bad++; end
    do_packet(lat, bs);
    total++; if (lat !== 6) begin $display("FAIL ovf_latency got=%0d want=6", lat); bad++; end
    total++; if (audio_sample_word[0] !== 24'ha00000 || audio_sample_word[7] !== 24'hb00003) begin
      $display("FAIL ovf_pkt1 got=%h/%h want=a00000/b00003", audio_sample_word[0], audio_sample_word[7]); bad++;
    end
    total++; if (sif.sample_ready !== 1'b1) begin $display("FAIL ovf_ready_back got=%b want=1", sif.sample_ready); bad++; end
    do_packet(lat, bs);
    total++; if (audio_sample_word[0] !== 24'ha00004 || audio_sample_word[6] !== 24'ha00007 || audio_sample_word[7] !== 24'hb00007) begin
      $display("FAIL ovf_pkt2 got=%h/%h/%h want=a00004/a00007/b00007",
               audio_sample_word[0], audio_sample_word[6], audio_sample_word[7]); bad++;
    end
    total++; if (frame_counter !== 8'd4) begin $display("FAIL ovf_fc got=%0d want=4", frame_counter); bad++; end
    // The rejected ninth sample must not appear.
    do_packet(lat, bs);
    total++; if (lat !== -1) begin $display("FAIL ovf_dropped got=%0d want=-1", lat); bad++; end
    total++; if (overflow !== 1'b1) begin $display("FAIL ovf_sticky got=%b want=1", overflow); bad++; end
  endtask

  task automatic test_reset_mid_drain();
    int   lat;
    logic bs;
    int   pulses;
    apply_reset();
    sif.sample_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      sif.sample_left  = 24'he00000 + 24'(i);
      sif.sample_right = 24'hf00000 + 24'(i);
      tick();
    end
    sif.sample_valid = 1'b0;
    total++; if (overflow !== 1'b1) begin $display("FAIL mid_ovf_pre got=%b want=1", overflow); bad++; end
    packet_req = 1'b1;
    tick();
    packet_req = 1'b0;
    tick();
    tick();
    total++; if (busy !== 1'b1) begin $display("FAIL mid_busy got=%b want=1", busy); bad++; end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (packet_valid === 1'b1) pulses++;
      tick();
    end
    total++; if (pulses !== 0) begin $display("FAIL mid_pulses got=%0d want=0", pulses); bad++; end
    total++; if (frame_counter !== 8'd0 || audio_sample_word_present !== 4'b0000) begin
      $display("FAIL mid_outputs got=fc%0d/p%b want=fc0/p0000", frame_counter, audio_sample_word_present); bad++;
    end
    total++; if (overflow !== 1'b0 || busy !== 1'b0 || sif.sample_ready !== 1'b1) begin
      $display("FAIL mid_flags got=o%b/b%b/r%b want=o0/b0/r1", overflow, busy, sif.sample_ready); bad++;
    end
    do_packet(lat, bs);
    total++; if (lat !== -1) begin $display("FAIL mid_fifo_empty got=%0d want=-1", lat); bad++; end
    push_sample(24'h0000aa, 24'h0000bb);
    do_packet(lat, bs);
    total++; if (lat !== 3 || frame_counter !== 8'd0 || audio_sample_word_present !== 4'b0001) begin
      $display("FAIL mid_after got=lat%0d/fc%0d/p%b want=lat3/fc0/p0001", lat, frame_counter, audio_sample_word_present); bad++;
    end
  endtask

  initial begin
    test_reset();
    test_full_packet();
    test_partial();
    test_frame_wrap();
    test_empty_and_ignore();
    test_overflow();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/audio_sample_buffer.md
Name: audio_sample_buffer

Overview:
- Upstream stage of the HDMI audio sample packet generator. Runs in the pixel clock domain.
- Accepts stereo L-PCM samples on a valid/ready handshake and holds them in a small FIFO.
- On each data-island packet request, drains up to 4 stereo samples into a packet slot set. Produces the word array, present mask and IEC 60958 frame counter that the sample packet generator consumes.
- Keeps the 192-frame channel-status position, advancing it by the number of samples actually sent.

Parameters:
- FIFO_DEPTH, 8, stereo-sample capacity; power of 2, minimum 4.
- AW, 3, FIFO address width; equals log2(FIFO_DEPTH).
- VALID_BIT_VALUE, 1'b0, IEC 60958 validity bit driven on both channels of present slots.
- USER_BIT_VALUE, 1'b0, user data bit driven on both channels of present slots.

Ports:
- clk_pixel  input  1  pixel clock, single clock domain.
- reset  input  1  synchronous, active-high reset.
- sample_valid  input  1  upstream sample available.
- sample_ready  output  1  FIFO can accept a sample.
- sample_left  input  24  left-channel word.
- sample_right  input  24  right-channel word.
- packet_req  input  1  one-cycle pulse: an audio sample packet slot is available.
- packet_valid  output  1  one-cycle pulse: packet outputs updated.
- frame_counter  output  8  channel-status frame index of slot 0, range 0..191.
- audio_sample_word  output  24 x [7:0]  word 2k = left of slot k, word 2k+1 = right of slot k.
- audio_sample_word_present  output  4  bit k set = slot k carries a sample.
- valid_bit  output  2 x [3:0]  per slot, [0] = left, [1] = right.
- user_data_bit  output  2 x [3:0]  per slot, [0] = left, [1] = right.
- busy  output  1  drain in progress.
- overflow  output  1  sticky; sample_valid seen while FIFO full.

Behaviour:
Reset values:
- sample_ready = 1 after reset. FIFO empty, count 0.
- packet_valid = 0, frame_counter = 0, all words = 0, present = 0, valid_bit = 0, user_data_bit = 0, busy = 0, overflow = 0.
- FSM returns to IDLE.
- Reset mid-drain discards the partial packet and all FIFO contents.

FIFO:
- Push when sample_valid && sample_ready.
- sample_ready = (count != FIFO_DEPTH).
- Push and pop in the same cycle leave count unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- overflow is set when sample_valid && !sample_ready. It is cleared only by reset. The sample offered in that case is not stored.

FSM states: IDLE, DRAIN, EMIT.
- IDLE:
  - On packet_req, snapshot n = min(count, 4) and clear the staging registers.
  - If n = 0, stay in IDLE and produce no packet_valid.
  - Otherwise go to DRAIN and set busy.
- DRAIN:
  - Pops one sample per cycle into staging slot k = 0..n-1, in FIFO order.
  - Sets staging present bit k, and staging valid/user bits from the parameters.
  - After the n-th pop, go to EMIT.
- EMIT:
  - Copy staging registers to the outputs. Unused slots carry words = 0, present = 0, valid/user = 0.
  - frame_counter output = internal counter fc.
  - Pulse packet_valid for one cycle, clear busy, return to IDLE.
  - Update fc: fc + n - 192 if fc + n >= 192, else fc + n. Use 9-bit intermediate arithmetic.

Timing and handshake rules:
- Latency: req at cycle t → pops at t+1..t+n → packet_valid registered at t+n+2. Maximum is t+6.
- packet_req while busy or in EMIT is ignored; it is neither queued nor counted.
- Pushes continue during DRAIN. Samples pushed after the snapshot wait for the next packet.
- Outputs hold their values between packet_valid pulses.
- Present mask is always contiguous from slot 0: 0001, 0011, 0111 or 1111.

Decomposition:
- Shared package hdmi_audio_pkg:
  - CHANNEL_STATUS_LENGTH = 192, SAMPLES_PER_PACKET = 4, AUDIO_WORD_WIDTH = 24.
  - FSM state enum for IDLE, DRAIN, EMIT.
- One sub-module, audio_sample_fifo: synchronous single-clock 48-bit FIFO with count output, parameterised by FIFO_DEPTH. It is reusable by other audio buffering.
- FSM, staging registers and frame counter stay in the top level.

Test Plan:
1. After reset, push 4 samples L = 0x000001..0x000004, R = 0x100001..0x100004; pulse packet_req → packet_valid 6 cycles later, present = 1111, word0 = 0x000001, word1 = 0x100001, word7 = 0x100004, frame_counter = 0; next packet reports frame_counter = 4.
2. Push 2 samples, then req → present = 0011, words 4..7 = 0, valid_bit = 0, packet_valid at t+4; push 3 more, req → present = 0111, frame_counter = 2.
3. Frame wrap: drive fc to 190 via 95 packets of 2 samples, then a 4-sample packet → frame_counter = 190, following packet frame_counter = 2.
4. Empty FIFO, req → no packet_valid, busy stays 0, outputs unchanged; a second req during DRAIN → ignored, only one packet_valid.
5. Hold sample_valid = 1 with no reqs → sample_ready drops after 8 pushes, overflow = 1 on the 9th attempt; one packet req then drains 4 samples and sample_ready returns to 1.
6. Assert reset during DRAIN after 2 pops → no packet_valid, count = 0, frame_counter = 0, present = 0, overflow = 0.
